// File: rtl/aes_seq_ctrl.sv
// Byte-serial AES block sequencer: steps a 16-byte block through load, NR-1
// mix-column rounds and a final round, and decodes all datapath strobes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start, counters held at zero
// S_LOAD  | plaintext byte taken each cycle, initial key add (round 0)
// S_ROUND | full rounds 1..NR-1 with MixColumns
// S_FINAL | last round, no MixColumns, ciphertext byte out each cycle
// S_DONE  | one-cycle completion pulse
module aes_seq_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       in_ready,
  output logic       pld,
  output logic [1:0] c3,
  output logic [7:0] mc_en,
  output logic       rk_en,
  output logic       rk_last_sel,
  output logic [3:0] round,
  output logic [3:0] byte_idx,
  output logic       out_valid,
  output logic       out_last
);

  localparam logic [3:0] NR_LAST = 4'(NR);
  localparam logic [3:0] NR_M1   = 4'(NR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] byte_nxt;
  logic [3:0] round_nxt;
  logic       active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_idx <= 4'd0;
      round    <= 4'd0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_nxt;
      round    <= round_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    byte_nxt  = byte_idx;
    round_nxt = round;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          byte_nxt  = 4'd0;
          round_nxt = 4'd0;
        end
      end
      S_LOAD, S_ROUND, S_FINAL: begin
        if (abort) begin
          state_nxt = S_IDLE;
          byte_nxt  = 4'd0;
          round_nxt = 4'd0;
        end else begin
          // 4-bit counter wraps 15->0 exactly at the round boundary
          byte_nxt = byte_idx + 4'd1;
          if (byte_idx == 4'd15) begin
            if (state == S_LOAD) begin
              state_nxt = S_ROUND;
              round_nxt = 4'd1;
            end else if (state == S_ROUND) begin
              if (round < NR_M1) begin
                round_nxt = round + 4'd1;
              end else begin
                state_nxt = S_FINAL;
                round_nxt = NR_LAST;
              end
            end else begin
              state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        byte_nxt  = 4'd0;
        round_nxt = 4'd0;
      end
      default: begin
        state_nxt = S_IDLE;
        byte_nxt  = 4'd0;
        round_nxt = 4'd0;
      end
    endcase
  end

  always_comb begin
    active      = (state == S_LOAD) || (state == S_ROUND) || (state == S_FINAL);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    in_ready    = (state == S_LOAD);
    rk_en       = active;
    rk_last_sel = (state == S_FINAL);
    out_valid   = (state == S_FINAL);
    out_last    = (state == S_FINAL) && (byte_idx == 4'd15);
    c3          = active ? byte_idx[1:0] : 2'd0;
    pld         = (state == S_ROUND) && (byte_idx[1:0] == 2'd3);
    mc_en       = 8'h00;
    if (state == S_ROUND) begin
      mc_en = {4'b0001 << byte_idx[3:2], 4'b0001 << byte_idx[1:0]};
    end
  end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Directed bench for aes_seq_ctrl: NR=10 and NR=2 instances checked cycle by
// cycle against the block timeline expected for each cycle after start.
module tb_aes_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, abort_a, start_b, abort_b;

  logic       busy_a, done_a, in_ready_a, pld_a, rk_en_a, rk_last_sel_a, out_valid_a, out_last_a;
  logic [1:0] c3_a;
  logic [7:0] mc_en_a;
  logic [3:0] round_a, byte_idx_a;

  logic       busy_b, done_b, in_ready_b, pld_b, rk_en_b, rk_last_sel_b, out_valid_b, out_last_b;
  logic [1:0] c3_b;
  logic [7:0] mc_en_b;
  logic [3:0] round_b, byte_idx_b;

  aes_seq_ctrl #(.NR(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .in_ready(in_ready_a), .pld(pld_a),
    .c3(c3_a), .mc_en(mc_en_a), .rk_en(rk_en_a), .rk_last_sel(rk_last_sel_a),
    .round(round_a), .byte_idx(byte_idx_a), .out_valid(out_valid_a), .out_last(out_last_a)
  );

  aes_seq_ctrl #(.NR(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .in_ready(in_ready_b), .pld(pld_b),
    .c3(c3_b), .mc_en(mc_en_b), .rk_en(rk_en_b), .rk_last_sel(rk_last_sel_b),
    .round(round_b), .byte_idx(byte_idx_b), .out_valid(out_valid_b), .out_last(out_last_b)
  );

  // [25]busy [24]done [23]in_ready [22]pld [21:20]c3 [19:12]mc_en [11]rk_en
  // [10]rk_last_sel [9:6]round [5:2]byte_idx [1]out_valid [0]out_last
  logic [25:0] obs_a, obs_b;
  assign obs_a = {busy_a, done_a, in_ready_a, pld_a, c3_a, mc_en_a, rk_en_a, rk_last_sel_a,
                  round_a, byte_idx_a, out_valid_a, out_last_a};
  assign obs_b = {busy_b, done_b, in_ready_b, pld_b, c3_b, mc_en_b, rk_en_b, rk_last_sel_b,
                  round_b, byte_idx_b, out_valid_b, out_last_b};

  int checks = 0;
  int errors = 0;
  int pld_cnt, ir_cnt, ov_cnt, last_cyc, done_cyc, done_cyc_b;

  // Expected outputs c cycles after the cycle in which start was sampled.
  function automatic logic [25:0] exp_vec(int c, int nr);
    logic [25:0] v;
    logic [3:0]  bi;
    logic [3:0]  rd;
    v = '0;
    if (c >= 1 && c <= 16 * (nr + 1)) begin
      bi = 4'((c - 1) % 16);
      rd = 4'((c - 1) / 16);
      v[25]    = 1'b1;
      v[11]    = 1'b1;
      v[21:20] = bi[1:0];
      v[9:6]   = rd;
      v[5:2]   = bi;
      if (rd == 4'd0) begin
        v[23] = 1'b1;
      end else if (int'(rd) < nr) begin
        v[19:16] = 4'b0001 << bi[3:2];
        v[15:12] = 4'b0001 << bi[1:0];
        v[22]    = (bi[1:0] == 2'd3);
      end else begin
        v[10] = 1'b1;
        v[1]  = 1'b1;
        v[0]  = (bi == 4'd15);
      end
    end else if (c == 16 * (nr + 1) + 1) begin
      v[25] = 1'b1;
      v[24] = 1'b1;
    end
    return v;
  endfunction

  // The round value in the DONE cycle is left unconstrained.
  function automatic logic [25:0] exp_mask(int c, int nr);
    logic [25:0] m;
    m = '1;
    if (c == 16 * (nr + 1) + 1) m[9:6] = 4'd0;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] expv,
                     input logic [25:0] m);
    checks++;
    assert ((obs & m) === (expv & m))
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs & m, expv & m);
      end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr();
    pld_cnt = 0; ir_cnt = 0; ov_cnt = 0; last_cyc = -1; done_cyc = -1; done_cyc_b = -1;
  endtask

  // Observes cycles c0..c1 (caller is positioned at cycle c0), ends on c1.
  task automatic run(input int c0, input int c1, input string tag, input bit with_b);
    for (int c = c0; c <= c1; c++) begin
      chk($sformatf("%s_a_c%0d", tag, c), obs_a, exp_vec(c, 10), exp_mask(c, 10));
      if (pld_a)       pld_cnt++;
      if (in_ready_a)  ir_cnt++;
      if (out_valid_a) ov_cnt++;
      if (out_last_a)  last_cyc = c;
      if (done_a)      done_cyc = c;
      if (with_b) begin
        chk($sformatf("%s_b_c%0d", tag, c), obs_b, exp_vec(c, 2), exp_mask(c, 2));
        if (done_b) done_cyc_b = c;
      end
      if (c < c1) tick();
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    tick(); tick();
    chk("reset_a", obs_a, 26'h0, '1);
    chk("reset_b", obs_b, 26'h0, '1);
    start_a = 1'b1; abort_a = 1'b1; start_b = 1'b1;
    tick();
    chk("reset_override_a", obs_a, 26'h0, '1);
    chk("reset_override_b", obs_b, 26'h0, '1);
    rst = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0;
    tick();
    chk("idle_a", obs_a, 26'h0, '1);

    // nominal block on both instances
    start_a = 1'b1; start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    clr();
    run(1, 177, "nom", 1'b1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    run(178, 180, "nom", 1'b1);
    chk_int("nom_pld_count", pld_cnt, 36);
    chk_int("nom_in_ready_count", ir_cnt, 16);
    chk_int("nom_out_valid_count", ov_cnt, 16);
    chk_int("nom_out_last_cycle", last_cyc, 176);
    chk_int("nom_done_cycle", done_cyc, 177);
    chk_int("nr2_done_cycle", done_cyc_b, 49);

    // abort mid-round, then restart with start and abort together
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    clr();
    run(1, 50, "abt", 1'b0);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abt_idle_c51", obs_a, 26'h0, '1);
    tick();
    chk("abt_idle_c52", obs_a, 26'h0, '1);
    chk_int("abt_no_done", done_cyc, -1);
    chk_int("abt_no_out_valid", ov_cnt, 0);
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    clr();
    run(1, 177, "restart", 1'b0);
    chk_int("restart_done_cycle", done_cyc, 177);
    chk_int("restart_out_valid_count", ov_cnt, 16);

    // start held high for the whole block and beyond
    tick();
    tick();
    start_a = 1'b1;
    tick();
    clr();
    run(1, 177, "held", 1'b0);
    tick();
    chk("held_idle_c178", obs_a, 26'h0, '1);
    tick();
    run(1, 88, "held2", 1'b0);
    chk_int("held2_round", int'(round_a), 5);
    chk_int("held2_byte_idx", int'(byte_idx_a), 7);

    // reset mid-round, overriding start and abort
    rst = 1'b1; abort_a = 1'b1;
    tick();
    chk("midrst_zero", obs_a, 26'h0, '1);
    rst = 1'b0; start_a = 1'b0; abort_a = 1'b0;
    tick();
    chk("midrst_idle", obs_a, 26'h0, '1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    clr();
    run(1, 178, "postrst", 1'b0);
    chk_int("postrst_done_cycle", done_cyc, 177);
    chk_int("postrst_pld_count", pld_cnt, 36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_seq_ctrl.md
AES_SEQ_CTRL -- requirements
Module: aes_seq_ctrl

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds; legal range 2..14.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 start  in  1  begin one 16-byte block; sampled only in IDLE.
REQ-005 abort  in  1  terminate the current block; sampled in any non-IDLE state.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse in the DONE state.
REQ-008 in_ready  out  1  high in LOAD; the datapath takes one plaintext byte on d_in every LOAD cycle.
REQ-009 pld  out  1  parallel load of mix-column results into the parallel/serial converter.
REQ-010 c3  out  2  byte-permutation (ShiftRows) row control.
REQ-011 mc_en  out  8  mix-column enables: [3:0] one-hot row select, [7:4] one-hot column select.
REQ-012 rk_en  out  1  advance the round-key byte stream by one byte.
REQ-013 rk_last_sel  out  1  selects the final-round key byte at the output XOR.
REQ-014 round  out  4  current round index.
REQ-015 byte_idx  out  4  current byte position within the round.
REQ-016 out_valid  out  1  the datapath d_out carries a ciphertext byte this cycle.
REQ-017 out_last  out  1  the final ciphertext byte of the block.

Function
REQ-018 FSM states: IDLE, LOAD, ROUND, FINAL, DONE; all outputs decoded from registered state and counters (Moore, no input-to-output path).
REQ-019 IDLE with start=1 -> LOAD next cycle, byte_idx=0, round=0; start=0 -> remain in IDLE.
REQ-020 byte_idx increments by 1 every cycle in LOAD, ROUND and FINAL, and wraps 15->0 at each round boundary.
REQ-021 LOAD at byte_idx=15 -> ROUND with round=1.
REQ-022 ROUND at byte_idx=15: if round<NR-1, round increments and the state stays ROUND; otherwise -> FINAL with round=NR.
REQ-023 FINAL at byte_idx=15 -> DONE; DONE -> IDLE unconditionally after one cycle.
REQ-024 Block latency: start sampled at cycle 0 -> LOAD cycles 1..16, ROUND cycles 17..16*NR, FINAL 16 cycles, DONE at cycle 16*(NR+1)+1.
REQ-025 c3 = byte_idx[1:0] in LOAD, ROUND and FINAL; c3 = 0 elsewhere.
REQ-026 mc_en in ROUND = {1<<byte_idx[3:2], 1<<byte_idx[1:0]}; mc_en = 8'h00 in all other states, so FINAL has no MixColumns.
REQ-027 pld = 1 only in ROUND with byte_idx[1:0]=3, which gives 4 pulses per round.
REQ-028 rk_en = 1 in LOAD, ROUND and FINAL; rk_en = 0 otherwise.
REQ-029 rk_last_sel = 1 only in FINAL.
REQ-030 out_valid = 1 for all 16 FINAL cycles; out_last = 1 only in FINAL with byte_idx=15.
REQ-031 start while busy=1 is ignored, including start in the DONE cycle.
REQ-032 abort=1 in LOAD, ROUND or FINAL -> IDLE next cycle with counters cleared, no done pulse and no further out_valid.
REQ-033 abort=1 in the DONE cycle is ignored; done still pulses.
REQ-034 start and abort high together in IDLE: start is accepted.
REQ-035 Counter widths: byte_idx 4 bits and round 4 bits, with no overflow for any NR in 2..14.

Reset
REQ-036 rst=1 at a clock edge -> state IDLE, byte_idx=0, round=0.
REQ-037 With rst=1, every output is 0 (busy, done, in_ready, pld, c3, mc_en, rk_en, rk_last_sel, round, byte_idx, out_valid, out_last).
REQ-038 rst overrides start and abort, and takes effect mid-block from any state.

Verification
REQ-039 NR=10, start pulse at cycle 0 -> in_ready cycles 1..16, pld high 36 times, out_valid cycles 161..176, out_last at cycle 176, done at cycle 177.
REQ-040 Integrated with the datapath, NR=10, key 000102..0f, plaintext 00112233445566778899aabbccddeeff -> d_out bytes under out_valid read 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-041 abort at cycle 50 -> busy=0 at cycle 51, no done, no out_valid; a new start at cycle 52 -> full block completes normally.
REQ-042 start held high through the whole block -> exactly one block, then a new LOAD begins one cycle after DONE.
REQ-043 rst in ROUND, round=5, byte_idx=7 -> all outputs 0 next cycle; start after rst deasserts -> nominal timing.
REQ-044 NR=2 -> one ROUND pass with round=1, FINAL with round=2, done at cycle 49.
